vending_controller: RTL and testbench
=====================================

// Module: vending_controller
// PURPOSE
//   Sequencing controller for the coin counter datapath of the vending machine.
//   Edge-detects coin_100/coin_500 inputs and accumulates credit.
//   Accepts a product selection, compares credit to price, and pulses dispense.
//   Returns change or a full refund as a train of 500/100 coin pulses.
// PARAMETERS
//   CREDIT_W       12    width of credit register (units of 1 colon)
//   PRICE_A        300   price of product A; must be a multiple of 100
//   PRICE_B        700   price of product B; must be a multiple of 100
//   MAX_CREDIT     1500  maximum credit; must be a multiple of 100 and < 2**CREDIT_W
//   TIMEOUT_CYCLES 1000  idle cycles before auto-refund (VEND_TIMEOUT_EN only)
// PORTS
//   clk          in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-low reset
//   coin_100     in   1         level from coin sensor; each rising edge is one 100 coin
//   coin_500     in   1         level from coin sensor; each rising edge is one 500 coin
//   sel_valid    in   1         one-cycle selection strobe
//   sel          in   1         0 = product A, 1 = product B; sampled with sel_valid
//   cancel       in   1         one-cycle refund request
//   credit       out  CREDIT_W  current credit (registered)
//   coin_reject  out  1         one-cycle pulse: detected coin was not accepted
//   insufficient out  1         one-cycle pulse: selection refused, credit < price
//   dispense     out  1         one-cycle pulse: release product
//   product_id   out  1         product being released; valid while dispense = 1
//   change_500   out  1         one-cycle pulse per returned 500 coin
//   change_100   out  1         one-cycle pulse per returned 100 coin
//   busy         out  1         high in DISPENSE and CHANGE states
// BEHAVIOUR
//   Reset (asynchronous, reset = 0)
//     - All outputs 0, credit = 0, state = IDLE, coin edge registers = 0.
//     - Reset mid-operation discards any credit and any pending change.
//   Coin edge detection
//     - Each coin input has a previous-value register; an edge is in & ~prev.
//     - Credit updates the cycle after the edge is detected (1-cycle latency).
//   States and transitions
//     - IDLE:     credit = 0. An accepted coin -> CREDIT.
//     - CREDIT:   accepts coins.
//                 sel_valid and credit >= price -> DISPENSE.
//                 sel_valid and credit < price -> insufficient pulse; stay in CREDIT.
//                 cancel -> CHANGE, returning the full credit.
//     - DISPENSE: 1 cycle. dispense = 1, product_id = sel, credit -= price.
//                 Next state is CHANGE if remaining credit > 0, else IDLE.
//     - CHANGE:   pulse pattern is 1 cycle high, then 1 cycle low.
//                 A change_500 pulse when credit >= 500 (credit -= 500);
//                 otherwise a change_100 pulse (credit -= 100).
//                 Moves to IDLE on the cycle credit reaches 0.
//   Coin acceptance and rejection
//     - A coin is rejected (coin_reject pulse, credit unchanged) if:
//       it arrives in DISPENSE or CHANGE, or accepting it would give credit > MAX_CREDIT.
//     - Both coin edges in the same cycle: coin_500 is evaluated first, then coin_100
//       against the updated total. Each coin is accepted or rejected on its own;
//       coin_reject pulses once if either coin is rejected.
//   Priority within CREDIT, same cycle
//     - cancel > sel_valid > coin. A coin arriving with cancel or an accepted
//       selection is rejected.
//   Width and range
//     - credit never exceeds MAX_CREDIT and never underflows.
//     - Because all values are multiples of 100, change always reaches exactly 0.
// CONFIGURATION
//   VEND_TIMEOUT_EN defined
//     - An inactivity counter runs in CREDIT and clears on any coin edge or sel_valid.
//     - When it reaches TIMEOUT_CYCLES, the block behaves exactly as if cancel were asserted.
//   VEND_TIMEOUT_EN undefined
//     - No counter is built; credit is held in CREDIT indefinitely.
//     - TIMEOUT_CYCLES is ignored.
// TESTING
//   1. Insert 100,100,500 (credit 700); sel_valid with sel = 1
//      -> dispense = 1, product_id = 1; credit 0; returns to IDLE with no change pulses.
//   2. Insert 500,500 (credit 1000); sel_valid with sel = 0
//      -> dispense; credit 700; then one change_500 and two change_100 pulses; IDLE.
//   3. Credit 200; sel_valid with sel = 0
//      -> insufficient pulse; credit stays 200; state stays CREDIT.
//   4. Credit 1400; insert 500 -> coin_reject, credit 1400.
//      Insert 100 -> credit 1500.
//   5. Credit 600; assert cancel
//      -> one change_500 and one change_100 pulse; credit 0; a coin inserted during CHANGE
//      -> coin_reject.
//   6. Credit 300; assert reset (low) during CHANGE
//      -> all outputs 0 immediately; IDLE after release.
//      With VEND_TIMEOUT_EN: credit 300 and no activity for TIMEOUT_CYCLES
//      -> three change_100 pulses.

Source files
------------

// File: rtl/vending_controller.sv
// Vending sequencer: coin edge detect, credit accumulate, dispense, then change/refund as 500/100 pulse train.
// Define VEND_TIMEOUT_EN to add an idle counter that auto-refunds after TIMEOUT_CYCLES in CREDIT.
module vending_controller #(
    parameter int CREDIT_W       = 12,
    parameter int PRICE_A        = 300,
    parameter int PRICE_B        = 700,
    parameter int MAX_CREDIT     = 1500,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic                sel_valid,
    input  logic                sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                dispense,
    output logic                product_id,
    output logic                change_500,
    output logic                change_100,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_A_V  = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_V  = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] COIN_100_V = CREDIT_W'(100);
    localparam logic [CREDIT_W-1:0] COIN_500_V = CREDIT_W'(500);
    localparam logic [CREDIT_W:0]   MAX_V      = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state, state_nxt;
    logic                phase, phase_nxt;
    logic                prev_100, prev_500;
    logic                edge_100, edge_500;
    logic                cancel_eff;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] sel_price, disp_price;
    logic                reject_nxt, insuff_nxt, disp_nxt, c500_nxt, c100_nxt;

    logic [CREDIT_W:0]   sum_500, base_100, sum_100;
    logic                acc_500, acc_100, coin_rej;
    logic [CREDIT_W-1:0] coin_total;

    assign edge_100 = coin_100 & ~prev_100;
    assign edge_500 = coin_500 & ~prev_500;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_V = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state != CREDIT || edge_100 || edge_500 || sel_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TMO_V) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign cancel_eff = cancel | (idle_cnt == TMO_V);
`else
    assign cancel_eff = cancel;
`endif

    // 500 coin is judged first; the 100 coin sees the total including an accepted 500.
    always_comb begin
        sum_500    = {1'b0, credit} + {1'b0, COIN_500_V};
        acc_500    = edge_500 && (sum_500 <= MAX_V);
        base_100   = acc_500 ? sum_500 : {1'b0, credit};
        sum_100    = base_100 + {1'b0, COIN_100_V};
        acc_100    = edge_100 && (sum_100 <= MAX_V);
        coin_total = acc_100 ? sum_100[CREDIT_W-1:0] : base_100[CREDIT_W-1:0];
        coin_rej   = (edge_500 && !acc_500) || (edge_100 && !acc_100);
    end

    assign sel_price  = sel ? PRICE_B_V : PRICE_A_V;
    assign disp_price = product_id ? PRICE_B_V : PRICE_A_V;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        phase_nxt  = 1'b0;
        reject_nxt = edge_100 | edge_500;
        insuff_nxt = 1'b0;
        disp_nxt   = 1'b0;
        c500_nxt   = 1'b0;
        c100_nxt   = 1'b0;
        case (state)
            IDLE: begin
                credit_nxt = coin_total;
                reject_nxt = coin_rej;
                if (acc_500 || acc_100) state_nxt = CREDIT;
            end
            CREDIT: begin
                if (cancel_eff) begin
                    state_nxt = CHANGE;
                end else if (sel_valid && credit >= sel_price) begin
                    state_nxt = DISPENSE;
                    disp_nxt  = 1'b1;
                end else begin
                    insuff_nxt = sel_valid;
                    credit_nxt = coin_total;
                    reject_nxt = coin_rej;
                end
            end
            DISPENSE: begin
                credit_nxt = credit - disp_price;
                state_nxt  = (credit == disp_price) ? IDLE : CHANGE;
            end
            CHANGE: begin
                // phase 0 emits a coin pulse, phase 1 is the low gap after it
                if (!phase) begin
                    if (credit >= COIN_500_V) begin
                        c500_nxt   = 1'b1;
                        credit_nxt = credit - COIN_500_V;
                    end else begin
                        c100_nxt   = 1'b1;
                        credit_nxt = credit - COIN_100_V;
                    end
                    if (credit_nxt == '0) state_nxt = IDLE;
                    else                  phase_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credit       <= '0;
            phase        <= 1'b0;
            prev_100     <= 1'b0;
            prev_500     <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            dispense     <= 1'b0;
            product_id   <= 1'b0;
            change_500   <= 1'b0;
            change_100   <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            phase        <= phase_nxt;
            prev_100     <= coin_100;
            prev_500     <= coin_500;
            coin_reject  <= reject_nxt;
            insufficient <= insuff_nxt;
            dispense     <= disp_nxt;
            product_id   <= disp_nxt & sel;
            change_500   <= c500_nxt;
            change_100   <= c100_nxt;
        end
    end

    assign busy = (state == DISPENSE) || (state == CHANGE);

endmodule

// File: tb/tb_vending_controller.sv
// Randomized + directed bench for vending_controller against a queue-based reference model.
module tb_vending_controller;
    localparam int TMO     = 1000;
    localparam int MAXC    = 1500;
    localparam int PRICE_A = 300;
    localparam int PRICE_B = 700;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        coin_100 = 1'b0, coin_500 = 1'b0, sel_valid = 1'b0, sel = 1'b0, cancel = 1'b0;
    logic [11:0] credit;
    logic        coin_reject, insufficient, dispense, product_id, change_500, change_100, busy;

    always #5 clk = ~clk;

    vending_controller #(
        .CREDIT_W(12), .PRICE_A(PRICE_A), .PRICE_B(PRICE_B),
        .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .credit(credit),
        .coin_reject(coin_reject), .insufficient(insufficient), .dispense(dispense),
        .product_id(product_id), .change_500(change_500), .change_100(change_100), .busy(busy)
    );

    // Expected outputs for one clock cycle.
    typedef struct {
        bit busy, disp, pid, c500, c100, rej, insuf;
        int credit;
    } exp_t;

    exp_t q[$];   // scheduled outputs of a dispense/change sequence, one per cycle
    exp_t cur;
    int   m_credit, idle_cnt;
    bit   m_p100, m_p500;

    int n_vec = 0, n_err = 0;
    int cnt_disp, cnt_c500, cnt_c100, cnt_rej, cnt_ins, last_pid;
    bit l100, l500, r_sv, r_s, r_cn;

    function automatic exp_t mk(bit b, bit d, bit p, bit c5, bit c1, int cr);
        exp_t e;
        e.busy = b; e.disp = d; e.pid = p; e.c500 = c5; e.c100 = c1;
        e.rej = 1'b0; e.insuf = 1'b0; e.credit = cr;
        return e;
    endfunction

    function automatic int price(bit s);
        return s ? PRICE_B : PRICE_A;
    endfunction

    // First cycle holds the full amount, then pulses alternate with gaps; the last pulse lands in idle.
    function automatic void push_train(int amount);
        int r, a;
        r = amount;
        q.push_back(mk(1, 0, 0, 0, 0, r));
        while (r > 0) begin
            a = (r >= 500) ? 500 : 100;
            r -= a;
            q.push_back(mk(r > 0, 0, 0, a == 500, a == 100, r));
            if (r > 0) q.push_back(mk(1, 0, 0, 0, 0, r));
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_credit = 0; idle_cnt = 0; m_p100 = 0; m_p500 = 0;
        cur = mk(0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_step(bit c100, bit c500, bit sv, bit s, bit cn);
        bit e100, e500, tmo, rej;
        int c;
        e100 = c100 & !m_p100;
        e500 = c500 & !m_p500;
        m_p100 = c100; m_p500 = c500;
        tmo = 1'b0;
`ifdef VEND_TIMEOUT_EN
        if (q.size() == 0 && m_credit > 0) tmo = (idle_cnt == TMO);
`endif
        if (q.size() != 0) begin
            cur = q.pop_front();
            cur.rej = e100 | e500;
            idle_cnt = 0;
        end else if (m_credit > 0 && (cn || tmo)) begin
            push_train(m_credit);
            m_credit = 0; idle_cnt = 0;
            cur = q.pop_front();
            cur.rej = e100 | e500;
        end else if (m_credit > 0 && sv && m_credit >= price(s)) begin
            q.push_back(mk(1, 1, s, 0, 0, m_credit));
            if (m_credit == price(s)) q.push_back(mk(0, 0, 0, 0, 0, 0));
            else                      push_train(m_credit - price(s));
            m_credit = 0; idle_cnt = 0;
            cur = q.pop_front();
            cur.rej = e100 | e500;
        end else begin
            c = m_credit; rej = 1'b0;
            if (e500) begin
                if (c + 500 <= MAXC) c += 500; else rej = 1'b1;
            end
            if (e100) begin
                if (c + 100 <= MAXC) c += 100; else rej = 1'b1;
            end
            cur = mk(0, 0, 0, 0, 0, c);
            cur.rej = rej;
            cur.insuf = (m_credit > 0) && sv;
            if (m_credit > 0 && !(e100 || e500 || sv)) idle_cnt++;
            else idle_cnt = 0;
            m_credit = c;
        end
    endfunction

    function automatic void check_all();
        bit ok;
        ok = (int'(credit) == cur.credit) && (coin_reject == cur.rej) && (insufficient == cur.insuf) &&
             (dispense == cur.disp) && (product_id == cur.pid) && (change_500 == cur.c500) &&
             (change_100 == cur.c100) && (busy == cur.busy);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL cycle_check t=%0t got credit=%0d rej=%b ins=%b disp=%b pid=%b c500=%b c100=%b busy=%b; expected credit=%0d rej=%b ins=%b disp=%b pid=%b c500=%b c100=%b busy=%b",
                     $time, credit, coin_reject, insufficient, dispense, product_id, change_500, change_100, busy,
                     cur.credit, cur.rej, cur.insuf, cur.disp, cur.pid, cur.c500, cur.c100, cur.busy);
        end
        if (dispense) begin cnt_disp++; last_pid = product_id; end
        if (change_500)   cnt_c500++;
        if (change_100)   cnt_c100++;
        if (coin_reject)  cnt_rej++;
        if (insufficient) cnt_ins++;
    endfunction

    function automatic void expect_lit(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endfunction

    function automatic void clr_cnt();
        cnt_disp = 0; cnt_c500 = 0; cnt_c100 = 0; cnt_rej = 0; cnt_ins = 0; last_pid = -1;
    endfunction

    task automatic apply(input bit c100, input bit c500, input bit sv, input bit s, input bit cn);
        coin_100 = c100; coin_500 = c500; sel_valid = sv; sel = s; cancel = cn;
        model_step(c100, c500, sv, s, cn);
    endtask

    task automatic step(input bit c100, input bit c500, input bit sv, input bit s, input bit cn);
        @(negedge clk);
        check_all();
        apply(c100, c500, sv, s, cn);
    endtask

    task automatic coin(input bit is500);
        step(!is500, is500, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        step(0, 0, 0, 0, 0);
        while ((busy || q.size() != 0) && k < 60) begin
            step(0, 0, 0, 0, 0);
            k++;
        end
        expect_lit("drain_timeout", (k >= 60) ? 1 : 0, 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        coin_100 = 0; coin_500 = 0; sel_valid = 0; sel = 0; cancel = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b1;
        apply(0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        clr_cnt();
        repeat (3) @(negedge clk);
        check_all();
        expect_lit("reset_credit", int'(credit), 0);
        reset = 1'b1;
        apply(0, 0, 0, 0, 0);

        // 100,100,500 then buy B: exact price, no change
        clr_cnt();
        coin(0); coin(0); coin(1);
        expect_lit("sc1_credit", int'(credit), 700);
        step(0, 0, 1, 1, 0);
        drain();
        expect_lit("sc1_disp", cnt_disp, 1);
        expect_lit("sc1_pid", last_pid, 1);
        expect_lit("sc1_change", cnt_c500 + cnt_c100, 0);
        expect_lit("sc1_credit_end", int'(credit), 0);

        // 500,500 then buy A: change 700 = 500+100+100
        clr_cnt();
        coin(1); coin(1);
        expect_lit("sc2_credit", int'(credit), 1000);
        step(0, 0, 1, 0, 0);
        drain();
        expect_lit("sc2_disp", cnt_disp, 1);
        expect_lit("sc2_pid", last_pid, 0);
        expect_lit("sc2_c500", cnt_c500, 1);
        expect_lit("sc2_c100", cnt_c100, 2);
        expect_lit("sc2_credit_end", int'(credit), 0);

        // credit 200, buy A: insufficient
        clr_cnt();
        coin(0); coin(0);
        step(0, 0, 1, 0, 0);
        drain();
        expect_lit("sc3_ins", cnt_ins, 1);
        expect_lit("sc3_credit", int'(credit), 200);
        expect_lit("sc3_disp", cnt_disp, 0);
        step(0, 0, 0, 0, 1);
        drain();

        // max credit boundary
        clr_cnt();
        coin(1); coin(1); coin(0); coin(0); coin(0); coin(0);
        expect_lit("sc4_credit", int'(credit), 1400);
        coin(1);
        expect_lit("sc4_rej", cnt_rej, 1);
        expect_lit("sc4_credit_hold", int'(credit), 1400);
        coin(0);
        expect_lit("sc4_credit_max", int'(credit), 1500);
        step(0, 0, 0, 0, 1);
        drain();

        // cancel at 600; coin during CHANGE is rejected
        clr_cnt();
        coin(1); coin(0);
        expect_lit("sc5_credit", int'(credit), 600);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        drain();
        expect_lit("sc5_rej", cnt_rej, 1);
        expect_lit("sc5_c500", cnt_c500, 1);
        expect_lit("sc5_c100", cnt_c100, 1);
        expect_lit("sc5_credit_end", int'(credit), 0);

        // reset during CHANGE
        coin(0); coin(0); coin(0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_lit("sc6_busy_before", int'(busy), 1);
        do_reset();
        expect_lit("sc6_credit_after", int'(credit), 0);
        drain();
        expect_lit("sc6_busy_after", int'(busy), 0);

        // randomized traffic
        l100 = 0; l500 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) l100 = !l100;
            if ($urandom_range(0, 3) == 0) l500 = !l500;
            r_sv = ($urandom_range(0, 5) == 0);
            r_s  = 1'($urandom_range(0, 1));
            r_cn = ($urandom_range(0, 24) == 0);
            step(l100, l500, r_sv, r_s, r_cn);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                l100 = 0; l500 = 0;
            end
        end
        step(0, 0, 0, 0, 1);
        drain();

`ifdef VEND_TIMEOUT_EN
        // idle timeout refunds 300 as three 100 pulses
        clr_cnt();
        coin(0); coin(0); coin(0);
        repeat (TMO + 10) step(0, 0, 0, 0, 0);
        drain();
        expect_lit("tmo_c100", cnt_c100, 3);
        expect_lit("tmo_c500", cnt_c500, 0);
        expect_lit("tmo_credit", int'(credit), 0);
`endif

        @(negedge clk);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
